// File: rtl/button_debounce_array.sv
// Per-channel push-button conditioner: synchronizer, debounce, edge pulses,
// and a hold FSM producing long-press and auto-repeat pulses.
module button_debounce_array #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pedge,
  output logic [N_BTN-1:0] btn_nedge,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ?
                        LONG_CYCLES : REPEAT_CYCLES;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HMAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]    sync;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nx;
    logic [HW-1:0] hinc;
    logic          level;
    logic          pedge;
    logic          nedge;
    logic          long_q;
    logic          rep_q;
    logic          long_nx;
    logic          rep_nx;
    logic          differ;
    logic          flip;
    logic          rise;
    logic          fall;
    state_t        st;
    state_t        st_nx;

    // Level flips on the differing clock after the counter holds the limit.
    assign differ = sync[1] ^ level;
    assign flip   = differ && (dcnt == DW'(DEBOUNCE_CYCLES));
    assign rise   = flip && !level;
    assign fall   = flip && level;
    assign hinc   = hcnt + HW'(1);

    always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
        sync   <= '0;
        dcnt   <= '0;
        level  <= 1'b0;
        pedge  <= 1'b0;
        nedge  <= 1'b0;
        long_q <= 1'b0;
        rep_q  <= 1'b0;
        hcnt   <= '0;
        st     <= IDLE;
      end else begin
        sync   <= {sync[0], btn[i]};
        dcnt   <= (!differ || flip) ? '0 : dcnt + DW'(1);
        level  <= level ^ flip;
        pedge  <= rise;
        nedge  <= fall;
        long_q <= long_nx;
        rep_q  <= rep_nx;
        hcnt   <= hcnt_nx;
        st     <= st_nx;
      end
    end

    always_comb begin
      st_nx   = st;
      hcnt_nx = hcnt;
      long_nx = 1'b0;
      rep_nx  = 1'b0;
      if (fall) begin
        st_nx   = IDLE;
        hcnt_nx = '0;
      end else begin
        case (st)
          IDLE: begin
            if (rise) begin
              st_nx   = HELD;
              hcnt_nx = '0;
            end
          end
          HELD: begin
            if (hinc == HW'(LONG_CYCLES)) begin
              long_nx = 1'b1;
              st_nx   = LONG;
              hcnt_nx = '0;
            end else begin
              hcnt_nx = hinc;
            end
          end
          LONG: begin
            if (hinc == HW'(REPEAT_CYCLES)) begin
              rep_nx  = 1'b1;
              hcnt_nx = '0;
            end else begin
              hcnt_nx = hinc;
            end
          end
          default: begin
            st_nx   = IDLE;
            hcnt_nx = '0;
          end
        endcase
      end
    end

    assign btn_level[i]  = level;
    assign btn_pedge[i]  = pedge;
    assign btn_nedge[i]  = nedge;
    assign btn_long[i]   = long_q;
    assign btn_repeat[i] = rep_q;
  end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench for button_debounce_array with short debounce/hold timing.
module tb_button_debounce_array;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [3:0] btn;
  logic [3:0] btn_level;
  logic [3:0] btn_pedge;
  logic [3:0] btn_nedge;
  logic [3:0] btn_long;
  logic [3:0] btn_repeat;

  int passed = 0;
  int total  = 0;

  button_debounce_array #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(16),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_p(reset_p),
    .btn(btn),
    .btn_level(btn_level),
    .btn_pedge(btn_pedge),
    .btn_nedge(btn_nedge),
    .btn_long(btn_long),
    .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] b;
    int         n;
    logic [3:0] lvl;
    logic [3:0] pe;
    logic [3:0] ne;
    logic [3:0] lg;
    logic [3:0] rp;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic [3:0] b, input int n,
                     input logic [3:0] lvl, input logic [3:0] pe,
                     input logic [3:0] ne, input logic [3:0] lg,
                     input logic [3:0] rp);
    vec_t v;
    v.rst = rst; v.b = b; v.n = n;
    v.lvl = lvl; v.pe = pe; v.ne = ne; v.lg = lg; v.rp = rp;
    vt.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [19:0] outs();
    return {btn_level, btn_pedge, btn_nedge, btn_long, btn_repeat};
  endfunction

  initial begin
    int k;
    int nl;
    int nr;
    int both;
    int lc;
    int rc;
    int extra;

    reset_p = 1'b1;
    btn     = 4'h0;

    // reset and idle
    add(1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch0 clean press: pedge on 7th edge (first sampling edge + 6)
    add(0, 4'h1, 6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h1, 1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    add(0, 4'h1, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 6, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
    add(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch1 3-clock glitch
    add(0, 4'h2, 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 20, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch1 bounce then steady
    add(0, 4'h2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h2, 6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h2, 1, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 7, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0);
    // ch0 and ch3 together
    add(0, 4'h9, 7, 4'h9, 4'h9, 4'h0, 4'h0, 4'h0);
    add(0, 4'h9, 1, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 7, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0);
    // ch2 press, reset mid-hold (n=0 checks the async clear)
    add(0, 4'h4, 7, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
    add(0, 4'h4, 9, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h4, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h4, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h4, 6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h4, 1, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
    // ch2 long press and repeats relative to the new pedge
    add(0, 4'h4, 15, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h4, 1, 4'h4, 4'h0, 4'h0, 4'h4, 4'h0);
    add(0, 4'h4, 3, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h4, 1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4);
    add(0, 4'h4, 3, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h4, 1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4);
    add(0, 4'h4, 4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4);
    add(0, 4'h0, 6, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0);
    add(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'h0, 8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    foreach (vt[i]) begin
      reset_p = vt[i].rst;
      btn     = vt[i].b;
      repeat (vt[i].n) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {12'h0, outs()},
            {12'h0, vt[i].lvl, vt[i].pe, vt[i].ne, vt[i].lg, vt[i].rp});
    end

    // ch3 hold sequence scanned cycle by cycle
    btn = 4'h8;
    k = 0;
    while (!btn_pedge[3] && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("ch3_pedge_latency", k, 7);
    nl = 0; nr = 0; both = 0; lc = 0; rc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (btn_long[3]) begin nl++; lc = c; end
      if (btn_repeat[3]) begin nr++; if (rc == 0) rc = c; end
      if (btn_long[3] && btn_repeat[3]) both++;
    end
    check("ch3_long_count", nl, 1);
    check("ch3_long_cycle", lc, 16);
    check("ch3_first_repeat", rc, 20);
    check("ch3_repeat_count", nr, 3);
    check("ch3_long_rep_overlap", both, 0);
    btn = 4'h0;
    k = 0;
    while (!btn_nedge[3] && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("ch3_nedge_latency", k, 7);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (btn_long[3] || btn_repeat[3] || btn_level[3]) extra++;
    end
    check("ch3_quiet_after_release", extra, 0);
    check("all_quiet_end", {12'h0, outs()}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
